// File: rtl/arp_decode.sv
// arp_decode: parses an Ethernet ARP payload, validates IPv4 requests aimed at IP_ADDR, and holds the requester's addresses for one reply
module arp_decode #(
  parameter logic [47:0] MAC_ADDR = 48'h0,
  parameter logic [31:0] IP_ADDR  = 32'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid_i,
  input  logic [7:0]  din_i,
  input  logic        in_last_i,
  output logic        reply_valid_o,
  input  logic        reply_ready_i,
  output logic [47:0] tha_o,
  output logic [31:0] tpa_o,
  output logic [7:0]  drop_cnt_o
);
  typedef enum logic {PARSE, DISCARD} state_t;
  localparam logic [63:0] HDR = 64'h0001_0800_0604_0001;
  state_t      state_q, state_d;
  logic [4:0]  idx_q, idx_d;
  logic [47:0] sha_c_q, sha_c_d, tha_q, tha_d;
  logic [31:0] spa_c_q, spa_c_d, tpa_q, tpa_d;
  logic [7:0]  drop_q, drop_d, exp_b;
  logic        rv_q, rv_d, chk, byte_ok, done, load;
  logic        unused_mac;
  assign unused_mac = ^MAC_ADDR;
  // per-beat field check, completion detection and next-state computation
  always_comb begin
    exp_b   = idx_q[4] ? IP_ADDR[{~idx_q[1:0], 3'b000} +: 8] : HDR[{~idx_q[2:0], 3'b000} +: 8];
    chk     = (idx_q < 5'd8) | ((idx_q >= 5'd24) & (idx_q < 5'd28));
    byte_ok = !chk | (din_i == exp_b);
    done    = in_valid_i & in_last_i & (state_q == PARSE) & byte_ok & (idx_q >= 5'd27);
    load    = done & (!rv_q | reply_ready_i);
    idx_d   = !in_valid_i ? idx_q : in_last_i ? 5'd0 : (idx_q == 5'd28) ? idx_q : idx_q + 5'd1;
    state_d = !in_valid_i ? state_q : in_last_i ? PARSE : byte_ok ? state_q : DISCARD;
    sha_c_d = (in_valid_i & (idx_q >= 5'd8) & (idx_q < 5'd14)) ? {sha_c_q[39:0], din_i} : sha_c_q;
    spa_c_d = (in_valid_i & (idx_q >= 5'd14) & (idx_q < 5'd18)) ? {spa_c_q[23:0], din_i} : spa_c_q;
    rv_d    = load | (rv_q & !reply_ready_i);
    tha_d   = load ? sha_c_q : tha_q;
    tpa_d   = load ? spa_c_q : tpa_q;
    drop_d  = (done & !load & (drop_q != 8'hFF)) ? drop_q + 8'd1 : drop_q;
  end
  // parser state, capture registers and the pending reply
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= PARSE;
      idx_q   <= '0;
      sha_c_q <= '0;
      spa_c_q <= '0;
      rv_q    <= 1'b0;
      tha_q   <= '0;
      tpa_q   <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      sha_c_q <= sha_c_d;
      spa_c_q <= spa_c_d;
      rv_q    <= rv_d;
      tha_q   <= tha_d;
      tpa_q   <= tpa_d;
      drop_q  <= drop_d;
    end
  end
  assign reply_valid_o = rv_q;
  assign tha_o         = tha_q;
  assign tpa_o         = tpa_q;
  assign drop_cnt_o    = drop_q;
endmodule

// File: tb/tb_arp_decode.sv
// tb_arp_decode: directed scoreboard bench for arp_decode
module tb_arp_decode;
  localparam logic [31:0] IP = 32'h0A000002;
  logic clk = 0, rst_n = 0, in_valid = 0, in_last = 0, reply_ready = 0, reply_valid;
  logic [7:0] din = 0, drop_cnt;
  logic [47:0] tha;
  logic [31:0] tpa;
  int checks = 0, errors = 0;
  logic [79:0] sb[$];
  logic prev_rv = 0, prev_x = 0, xfer;
  logic [79:0] prev_d;
  arp_decode #(.MAC_ADDR(48'h02AABBCCDDEE), .IP_ADDR(IP)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid), .din_i(din), .in_last_i(in_last),
    .reply_valid_o(reply_valid), .reply_ready_i(reply_ready), .tha_o(tha), .tpa_o(tpa),
    .drop_cnt_o(drop_cnt));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk); #1;
    in_valid = 0;
    in_last = 0;
  endtask
  task automatic send(input logic [47:0] sha, input logic [31:0] spa, input logic [31:0] tp,
                      input logic [15:0] op, input logic [15:0] pt, input int len, input bit rdy_last);
    logic [223:0] f;
    f = {16'h0001, pt, 8'h06, 8'h04, op, sha, spa, 48'h0, tp};
    for (int i = 0; i < len; i++) begin
      @(posedge clk); #1;
      in_valid = 1;
      din = (i < 28) ? f[8*(27-i) +: 8] : 8'h00;
      in_last = (i == len - 1);
      if (rdy_last && i == len - 1) reply_ready = 1;
    end
  endtask
  // handshake monitor: pops the scoreboard on each transfer and checks pending data is held
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_rv = 0;
      prev_x = 0;
    end else begin
      if (prev_rv && !prev_x) begin
        chk("hold_valid", 80'(reply_valid), 80'd1);
        chk("hold_data", {tha, tpa}, prev_d);
      end
      xfer = reply_valid && reply_ready;
      if (xfer) begin
        if (sb.size() == 0) chk("xfer_expected", 80'(sb.size()), 80'd1);
        else chk("xfer_data", {tha, tpa}, sb.pop_front());
      end
      prev_rv = reply_valid;
      prev_x = xfer;
      prev_d = {tha, tpa};
    end
  end
  initial begin
    logic [15:0] bop[4], bpt[4];
    logic [31:0] btp[4];
    int blen[4];
    bop = '{16'h0002, 16'h0001, 16'h0001, 16'h0001};
    bpt = '{16'h0800, 16'h0800, 16'h86DD, 16'h0800};
    btp = '{IP, 32'h0A000003, IP, IP};
    blen = '{28, 28, 28, 21};
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 80'(reply_valid), 80'd0);
    chk("rst_addr", {tha, tpa}, 80'd0);
    chk("rst_drop", 80'(drop_cnt), 80'd0);
    @(negedge clk) rst_n = 1;
    // basic request, ready high
    reply_ready = 1;
    sb.push_back({48'h021122334455, 32'h0A000007});
    send(48'h021122334455, 32'h0A000007, IP, 16'h0001, 16'h0800, 28, 0);
    chk("latency_pre", 80'(reply_valid), 80'd0);
    step();
    chk("latency_valid", 80'(reply_valid), 80'd1);
    chk("t1_tha", 80'(tha), 80'h021122334455);
    chk("t1_tpa", 80'(tpa), 80'h0A000007);
    step();
    chk("t1_clear", 80'(reply_valid), 80'd0);
    // padded frame held while ready low
    reply_ready = 0;
    sb.push_back({48'h0A0B0C0D0E0F, 32'hC0A80101});
    send(48'h0A0B0C0D0E0F, 32'hC0A80101, IP, 16'h0001, 16'h0800, 46, 0);
    step();
    chk("pad_valid", 80'(reply_valid), 80'd1);
    chk("pad_tha", 80'(tha), 80'h0A0B0C0D0E0F);
    repeat (10) step();
    chk("pad_drop", 80'(drop_cnt), 80'd0);
    reply_ready = 1;
    step();
    chk("pad_clear", 80'(reply_valid), 80'd0);
    // malformed frames and a runt, each followed immediately by a good frame
    for (int k = 0; k < 4; k++) begin
      send(48'h021122334455, 32'h0A000007, btp[k], bop[k], bpt[k], blen[k], 0);
      sb.push_back({48'h111111111100 + 48'(k), 32'h0A000010 + 32'(k)});
      send(48'h111111111100 + 48'(k), 32'h0A000010 + 32'(k), IP, 16'h0001, 16'h0800, 28, 0);
      step();
      chk("bad_follow_valid", 80'(reply_valid), 80'd1);
      chk("bad_follow_tha", 80'(tha), 80'(48'h111111111100 + 48'(k)));
      chk("bad_drop", 80'(drop_cnt), 80'd0);
      step();
    end
    // back-to-back with ready low, then saturate the drop counter
    reply_ready = 0;
    sb.push_back({48'hAAAAAAAAAA01, 32'h0A000101});
    send(48'hAAAAAAAAAA01, 32'h0A000101, IP, 16'h0001, 16'h0800, 28, 0);
    send(48'hBBBBBBBBBB02, 32'h0A000102, IP, 16'h0001, 16'h0800, 28, 0);
    step();
    chk("b2b_tha", 80'(tha), 80'hAAAAAAAAAA01);
    chk("b2b_drop", 80'(drop_cnt), 80'd1);
    for (int k = 0; k < 300; k++)
      send(48'hCCCCCCCC0000 + 48'(k), 32'h0A000200, IP, 16'h0001, 16'h0800, 28, 0);
    step();
    chk("sat_drop", 80'(drop_cnt), 80'd255);
    chk("sat_tha", 80'(tha), 80'hAAAAAAAAAA01);
    reply_ready = 1;
    step();
    chk("sat_clear", 80'(reply_valid), 80'd0);
    // completion in the same cycle as the handshake reloads
    reply_ready = 0;
    sb.push_back({48'hD0D1D2D3D4D5, 32'h0A000301});
    send(48'hD0D1D2D3D4D5, 32'h0A000301, IP, 16'h0001, 16'h0800, 28, 0);
    step();
    chk("same_a_tha", 80'(tha), 80'hD0D1D2D3D4D5);
    sb.push_back({48'hE0E1E2E3E4E5, 32'h0A000302});
    send(48'hE0E1E2E3E4E5, 32'h0A000302, IP, 16'h0001, 16'h0800, 28, 1);
    step();
    reply_ready = 0;
    chk("same_valid", 80'(reply_valid), 80'd1);
    chk("same_b_addr", {tha, tpa}, {48'hE0E1E2E3E4E5, 32'h0A000302});
    chk("same_drop", 80'(drop_cnt), 80'd255);
    // asynchronous reset mid-frame
    send(48'h123456789ABC, 32'h0A000400, IP, 16'h0001, 16'h0800, 10, 0);
    in_last = 0;
    #2 rst_n = 0;
    #1;
    chk("arst_valid", 80'(reply_valid), 80'd0);
    chk("arst_addr", {tha, tpa}, 80'd0);
    chk("arst_drop", 80'(drop_cnt), 80'd0);
    in_valid = 0;
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1;
    reply_ready = 1;
    sb.push_back({48'h5A5A5A5A5A5A, 32'h0A000505});
    send(48'h5A5A5A5A5A5A, 32'h0A000505, IP, 16'h0001, 16'h0800, 28, 0);
    step();
    chk("post_rst_valid", 80'(reply_valid), 80'd1);
    chk("post_rst_addr", {tha, tpa}, {48'h5A5A5A5A5A5A, 32'h0A000505});
    repeat (3) step();
    chk("sb_drained", 80'(sb.size()), 80'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/arp_decode.md
# arp_decode

Receive-side ARP parser sitting directly upstream of the ARP reply encoder. Consumes the byte stream of an Ethernet payload (first byte after EtherType 0x0806), validates that it is an IPv4-over-Ethernet ARP request addressed to this device, and captures the requester's hardware and protocol addresses. It then presents those addresses as `tha`/`tpa` with a valid/ready handshake that launches one reply.

## Interface

Parameters:

- `MAC_ADDR`, 48'h0, this device's MAC (informational; not checked against THA).
- `IP_ADDR`, 32'h0, this device's IPv4 address; TPA must equal it.

Ports:

- `clk`  in  1  sole clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  `din` carries a payload byte this cycle.
- `din`  in  8  payload byte, network order (MSB of each field first).
- `in_last`  in  1  qualifies with `in_valid`; marks final byte of frame, including padding.
- `reply_valid`  out  1  a validated request is pending.
- `reply_ready`  in  1  encoder accepts the pending request.
- `tha`  out  48  SHA of the request; becomes the reply's THA.
- `tpa`  out  32  SPA of the request; becomes the reply's TPA.
- `drop_cnt`  out  8  saturating count of well-formed requests for us that were lost because a reply was still pending.

## Operation

- Byte index `idx` (5 bits) counts accepted beats from 0 and saturates at 28. It resets to 0 after any beat with `in_last`.
- Field checks, applied per byte; any mismatch clears a sticky `ok` flag for the frame:
  - idx 0-1 = 00 01 (HTYPE Ethernet).
  - idx 2-3 = 08 00 (PTYPE IPv4).
  - idx 4 = 06 (HLEN); idx 5 = 04 (PLEN).
  - idx 6-7 = 00 01 (opcode request; replies are dropped).
  - idx 8-13: shift into capture register `sha_c`.
  - idx 14-17: shift into capture register `spa_c`.
  - idx 18-23: THA, ignored.
  - idx 24-27: compare to `IP_ADDR`, byte 24 against `IP_ADDR[31:24]`.
- Bytes at idx ≥ 28 (Ethernet padding) are ignored.
- States:
  - **PARSE**: accepting frame bytes.
  - **DISCARD**: `ok` cleared; consume bytes until `in_last`, then go to PARSE.
  - The pending output is a separate flag, `reply_valid`, orthogonal to the parse state.
- Frame complete: beat with `in_last`, `ok`=1 and idx reached 28 (idx 27 with `in_last` counts as complete). Otherwise the frame is silently dropped, including runts where `in_last` arrives before idx 27.
- On frame complete:
  - If `reply_valid`=0, or `reply_ready`=1 in the same cycle: load `tha`←`sha_c`, `tpa`←`spa_c`, and set `reply_valid`.
  - Otherwise: increment `drop_cnt`, saturating at 255. Outputs stay untouched.
- `tha`/`tpa` hold stable whenever `reply_valid`=1. Parsing a new frame never disturbs them; it writes only the capture registers.
- `reply_valid` clears on `reply_ready`=1, unless a new completion reloads it in the same cycle.

## Timing

- Reset, asynchronous on `rst_n` low: `reply_valid`=0, `tha`=0, `tpa`=0, `drop_cnt`=0, idx=0, state PARSE, `ok`=1, capture registers 0.
- Latency: `reply_valid` rises on the clock edge that samples the completing `in_last` beat, i.e. visible the next cycle.
- The handshake transfers when `reply_valid` & `reply_ready` are both high at a clock edge. `reply_ready` while `reply_valid`=0 is ignored.
- `in_valid`=0 cycles are bubbles; no state changes. There is no backpressure on input; every valid beat is consumed.
- Reset asserted mid-frame or mid-pending clears everything. The first valid beat after release is treated as idx 0.
- Back-to-back frames (`in_last` then `in_valid` the next cycle) must parse correctly with no idle gap.

## Test plan

- Valid 28-byte request, SHA 02:11:22:33:44:55, SPA 10.0.0.7, TPA=`IP_ADDR`=10.0.0.2, `reply_ready`=1 -> `reply_valid` high exactly one cycle after `in_last`, `tha`=48'h021122334455, `tpa`=32'h0A000007.
- Same request with 18 padding bytes, `in_last` on byte 46, `reply_ready`=0 for 10 cycles -> `reply_valid` held, outputs stable, drop on ready.
- Opcode 00 02, or TPA 10.0.0.3, or PTYPE 86 DD -> no `reply_valid`, `drop_cnt` unchanged; a valid frame following immediately is accepted.
- Runt: `in_last` at idx 20 -> dropped. The next frame parses from idx 0 correctly.
- Two valid requests back-to-back, `reply_ready`=0 -> first is held, `drop_cnt`=1. Repeat 300 times -> `drop_cnt`=255.
- Second frame completes in the same cycle `reply_ready`=1 -> `reply_valid` stays 1 and outputs switch to the second frame's SHA/SPA. Then `rst_n` low mid-frame -> all outputs 0 asynchronously.
